// File: rtl/coord_scanner.sv
// coord_scanner: raster coordinate generator. Walks an H_RES x V_RES frame in
// raster order and streams each pixel's X/Y with its complex-plane coordinate
// (a, b) over a valid/ready interface. Coordinates are built incrementally by
// accumulating the latched per-pixel and per-line steps.
// Optional feature macro: COORD_SCANNER_STALL_CNT_EN adds the stall_count output.
module coord_scanner #(
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] delta_x,
   input  logic [31:0] delta_y,
   input  logic [31:0] re_origin,
   input  logic [31:0] im_origin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [9:0]  X,
   output logic [9:0]  Y,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic        eol,
   output logic        eof,
   output logic        busy,
   output logic        frame_done
`ifdef COORD_SCANNER_STALL_CNT_EN
   ,
   output logic [31:0] stall_count
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   localparam logic [9:0] X_LAST = 10'(H_RES - 1);
   localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

   state_t      state;
   logic [31:0] dx_q;
   logic [31:0] dy_q;
   logic [31:0] re_q;
   logic [31:0] im_q;

   // Frame sequencer: latches the view window, advances the raster position
   // and coordinate accumulators on each transfer, and drives all stream flags.
   // eol/eof are precomputed from the next position so they stay registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dx_q       <= '0;
         dy_q       <= '0;
         re_q       <= '0;
         im_q       <= '0;
         out_valid  <= 1'b0;
         X          <= '0;
         Y          <= '0;
         a          <= '0;
         b          <= '0;
         eol        <= 1'b0;
         eof        <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dx_q      <= delta_x;
                  dy_q      <= delta_y;
                  re_q      <= re_origin;
                  im_q      <= im_origin;
                  X         <= '0;
                  Y         <= '0;
                  a         <= re_origin;
                  b         <= im_origin;
                  eol       <= 1'b0;
                  eof       <= 1'b0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (out_ready) begin
                  if (X != X_LAST) begin
                     X   <= X + 10'd1;
                     a   <= a + dx_q;
                     eol <= (X + 10'd1 == X_LAST);
                     eof <= (X + 10'd1 == X_LAST) && (Y == Y_LAST);
                  end else if (Y != Y_LAST) begin
                     X   <= '0;
                     Y   <= Y + 10'd1;
                     a   <= re_q;
                     b   <= b + dy_q;
                     eol <= 1'b0;
                     eof <= 1'b0;
                  end else begin
                     out_valid  <= 1'b0;
                     eol        <= 1'b0;
                     eof        <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COORD_SCANNER_STALL_CNT_EN
   // Saturating count of stalled beats; cleared by a new frame, held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (state == IDLE && start) begin
         stall_count <= '0;
      end else if (state == SCAN && !out_ready && stall_count != '1) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_coord_scanner.sv
// tb_coord_scanner: scoreboard bench for coord_scanner on a 4x3 frame.
// Expected beats come from closed-form coordinates (origin + index * step).
module tb_coord_scanner;

   localparam int unsigned H = 4;
   localparam int unsigned V = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] delta_x;
   logic [31:0] delta_y;
   logic [31:0] re_origin;
   logic [31:0] im_origin;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  X;
   logic [9:0]  Y;
   logic [31:0] a;
   logic [31:0] b;
   logic        eol;
   logic        eof;
   logic        busy;
   logic        frame_done;
`ifdef COORD_SCANNER_STALL_CNT_EN
   logic [31:0] stall_count;
`endif

   coord_scanner #(.H_RES(H), .V_RES(V)) dut (
      .clk(clk), .rst(rst), .start(start),
      .delta_x(delta_x), .delta_y(delta_y),
      .re_origin(re_origin), .im_origin(im_origin),
      .out_valid(out_valid), .out_ready(out_ready),
      .X(X), .Y(Y), .a(a), .b(b), .eol(eol), .eof(eof),
      .busy(busy), .frame_done(frame_done)
`ifdef COORD_SCANNER_STALL_CNT_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [31:0] a;
      logic [31:0] b;
      logic        eol;
      logic        eof;
   } beat_t;

   beat_t q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: every pixel's coordinate is origin + index * step, modulo 2^32.
   task automatic push_frame(input logic [31:0] re, input logic [31:0] im,
                             input logic [31:0] dx, input logic [31:0] dy);
      beat_t e;
      for (int unsigned y = 0; y < V; y++) begin
         for (int unsigned x = 0; x < H; x++) begin
            e.x   = 10'(x);
            e.y   = 10'(y);
            e.a   = re + 32'(x) * dx;
            e.b   = im + 32'(y) * dy;
            e.eol = (x == H - 1);
            e.eof = (x == H - 1) && (y == V - 1);
            q.push_back(e);
         end
      end
   endtask

   // Ready driver: 0 = always ready, 1 = random, 2 = hold low 5 cycles at beat 2
   int ready_mode = 0;
   int stall_left = 0;
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: out_ready = ($urandom_range(0, 3) != 0);
         2: begin
            if (out_valid && X == 10'd2 && Y == 10'd0 && stall_left > 0) begin
               out_ready = 1'b0;
               stall_left--;
            end else begin
               out_ready = 1'b1;
            end
         end
         default: out_ready = 1'b1;
      endcase
   end

   // Monitor: compares presented beats with the scoreboard head, tracks frame timing
   beat_t       mon_e;
   logic        fd_exp = 1'b0;
   logic        in_frame = 1'b0;
   int unsigned first_cyc = 0;
   int unsigned last_eof_cyc = 0;
   int unsigned nbeats = 0;
   int unsigned nstall = 0;
   int unsigned last_stall = 0;
   logic        btb_arm = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         fd_exp   = 1'b0;
         in_frame = 1'b0;
         nbeats   = 0;
         nstall   = 0;
      end else begin
         check("frame_done", frame_done, fd_exp);
`ifdef COORD_SCANNER_STALL_CNT_EN
         if (frame_done) check("stall_count_frame", stall_count, last_stall);
`endif
         fd_exp = 1'b0;
         if (out_valid) begin
            if (!in_frame) begin
               in_frame  = 1'b1;
               first_cyc = cyc;
               if (btb_arm) begin
                  check("back_to_back_gap", cyc - last_eof_cyc, 3);
                  btb_arm = 1'b0;
               end
            end
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got X=%0d Y=%0d expected no beat", X, Y);
            end else begin
               mon_e = q[0];
               check("beat", {X, Y, a, b, eol, eof}, mon_e);
               if (out_ready) begin
                  void'(q.pop_front());
                  nbeats++;
                  if (mon_e.eof) begin
                     fd_exp = 1'b1;
                     check("frame_beats", nbeats, H * V);
                     check("frame_cycles", cyc - first_cyc, H * V - 1 + nstall);
                     last_stall   = nstall;
                     last_eof_cyc = cyc;
                     nbeats       = 0;
                     nstall       = 0;
                     in_frame     = 1'b0;
                  end
               end else begin
                  nstall++;
               end
            end
         end
      end
   end

   task automatic scramble();
      delta_x   = $urandom;
      delta_y   = $urandom;
      re_origin = $urandom;
      im_origin = $urandom;
   endtask

   task automatic start_frame(input logic [31:0] re, input logic [31:0] im,
                              input logic [31:0] dx, input logic [31:0] dy);
      @(posedge clk); #1;
      re_origin = re;
      im_origin = im;
      delta_x   = dx;
      delta_y   = dy;
      start     = 1'b1;
      push_frame(re, im, dx, dy);
      @(posedge clk); #1;
      start = 1'b0;
      scramble();
      check("first_beat_latency", out_valid, 1'b1);
      check("busy_scan", busy, 1'b1);
   endtask

   // Returns in the cycle where frame_done is high
   task automatic wait_done(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, got no frame_done expected pulse", name);
      end else begin
         check("busy_done", busy, 1'b1);
      end
   endtask

   initial begin
      logic seen6;
      rst = 1'b1;
      start = 1'b0;
      delta_x = '0;
      delta_y = '0;
      re_origin = '0;
      im_origin = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {out_valid, X, Y, a, b, eol, eof, busy, frame_done}, '0);
`ifdef COORD_SCANNER_STALL_CNT_EN
      check("reset_stall_count", stall_count, '0);
`endif
      rst = 1'b0;

      // Basic frame
      ready_mode = 0;
      start_frame(32'hFFFE0000, 32'h00010000, 32'h00008000, 32'hFFFF8000);
      wait_done("basic");

      // start sampled in DONE must be ignored
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("start_in_done_ignored", {out_valid, busy}, 2'b00);
      check("idle_after_done", frame_done, 1'b0);

      // Backpressure: 5 stall cycles at beat 2
      ready_mode = 2;
      stall_left = 5;
      start_frame($urandom, $urandom, $urandom, $urandom);
      wait_done("backpressure");
      ready_mode = 0;
`ifdef COORD_SCANNER_STALL_CNT_EN
      check("stall_count_5", stall_count, 32'd5);
      repeat (3) @(posedge clk);
      #1;
      check("stall_count_hold", stall_count, 32'd5);
`endif

      // Arithmetic wrap
      start_frame(32'h7FFFFFFF, $urandom, 32'd1, $urandom);
      wait_done("wrap");

      // start during SCAN with new values is ignored
      start_frame(32'h00001000, 32'h00002000, 32'h00000100, 32'h00000200);
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      scramble();
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("start_in_scan");

      // Reset at beat 6 abandons the frame
      start_frame($urandom, $urandom, $urandom, $urandom);
      seen6 = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (out_valid && X == 10'd2 && Y == 10'd1) begin
            seen6 = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("reach_beat6", seen6, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_frame_reset", {out_valid, X, Y, a, b, eol, eof, busy, frame_done}, '0);
      repeat (3) begin
         @(posedge clk); #1;
         check("no_done_after_reset", {frame_done, out_valid}, 2'b00);
      end
      start_frame($urandom, $urandom, $urandom, $urandom);
      wait_done("after_reset");

      // Back-to-back frames with start held high
      @(posedge clk); #1;
      scramble();
      start = 1'b1;
      push_frame(re_origin, im_origin, delta_x, delta_y);
      wait_done("btb_first");
      scramble();
      push_frame(re_origin, im_origin, delta_x, delta_y);
      btb_arm = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("btb_second");
      check("btb_gap_checked", btb_arm, 1'b0);

      // Random frames with random backpressure
      ready_mode = 1;
      for (int n = 0; n < 4; n++) begin
         start_frame($urandom, $urandom, $urandom, $urandom);
         wait_done("random");
      end
      ready_mode = 0;

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/coord_scanner.md
# coord_scanner

Raster coordinate generator that drives the pixel-to-complex-plane mapping stage from the producer side. On `start` it latches the view window, walks every pixel of an `H_RES` x `V_RES` frame in raster order, and presents each pixel's `X`/`Y` together with its complex coordinate (`a`, `b`) over a valid/ready stream. It computes `a`/`b` incrementally by accumulating `delta_x`/`delta_y`, so the iteration engine can consume coordinates at one per cycle without per-pixel multipliers.

## Interface
- `H_RES`, 640, pixels per line; 2..1024.
- `V_RES`, 480, lines per frame; 2..1024.
- `clk`  in  1  rising-edge clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; honoured only in IDLE.
- `delta_x`  in  32  real-axis step per pixel, two's-complement fixed point; sampled on accepted `start`.
- `delta_y`  in  32  imaginary-axis step per line; sampled on accepted `start`.
- `re_origin`  in  32  real coordinate of pixel (0,0); sampled on accepted `start`.
- `im_origin`  in  32  imaginary coordinate of pixel (0,0); sampled on accepted `start`.
- `out_valid`  out  1  current beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `X`  out  10  pixel column.
- `Y`  out  10  pixel row.
- `a`  out  32  real coordinate of (`X`,`Y`).
- `b`  out  32  imaginary coordinate of (`X`,`Y`).
- `eol`  out  1  beat is the last pixel of a line (`X`==`H_RES`-1).
- `eof`  out  1  beat is the last pixel of the frame.
- `busy`  out  1  high in SCAN and DONE.
- `frame_done`  out  1  single-cycle pulse after the final beat transfers.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: `start`=1 latches `delta_x`, `delta_y`, `re_origin`, `im_origin`; loads X=0, Y=0, a=re_origin, b=im_origin; moves to SCAN.
- SCAN: `out_valid`=1. Transfer = `out_valid` && `out_ready`. On transfer:
  - X<`H_RES`-1: X+1, a+=delta_x.
  - X==`H_RES`-1, Y<`V_RES`-1: X=0, Y+1, a=re_origin, b+=delta_y.
  - X==`H_RES`-1, Y==`V_RES`-1: to DONE.
- DONE: `frame_done`=1 for exactly one cycle; then IDLE.
- No transfer: X, Y, a, b, `eol`, `eof` held stable while `out_valid`=1.
- Arithmetic: 32-bit add, wraps modulo 2^32, no saturation and no overflow flag.
- `start` in SCAN or DONE is ignored. Input changes after latch have no effect on the running frame.
- `start` in the same cycle that DONE returns to IDLE is not honoured. A new frame needs `start` sampled in IDLE.
- Reset at any time: forces IDLE, abandons the frame in flight, and does not pulse `frame_done`.

## Timing
- Reset values: `out_valid`=0, X=0, Y=0, a=0, b=0, `eol`=0, `eof`=0, `busy`=0, `frame_done`=0. Latched parameters clear to 0.
- `start` sampled in cycle N gives first beat with `out_valid`=1 in cycle N+1.
- Throughput: one beat per cycle with `out_ready` held high.
- Frame length: `H_RES`*`V_RES` transfers.
- `frame_done` asserts the cycle after the final transfer. The earliest accepted restart is `start` sampled in the cycle after `frame_done`.
- All outputs are registered; no combinational path from `out_ready` to any output.

## Configuration
- `COORD_SCANNER_STALL_CNT_EN` defined:
  - adds output `stall_count` (out, 32), counting cycles with `out_valid`=1 and `out_ready`=0;
  - clears on accepted `start` and on reset;
  - saturates at 0xFFFFFFFF;
  - holds its value after the frame ends.
- Not defined: `stall_count` port and its logic are absent; all other behaviour is identical.

## Test plan
- Basic frame, `H_RES`=4, `V_RES`=3, re_origin=0xFFFE0000, im_origin=0x00010000, delta_x=0x00008000, delta_y=0xFFFF8000, ready=1 -> 12 beats in 12 consecutive cycles:
  - beat 0: a=0xFFFE0000, b=0x00010000;
  - beat 3: a=0xFFFF8000, `eol`=1;
  - beat 4: X=0, Y=1, a=0xFFFE0000, b=0x00008000;
  - beat 11: `eof`=1;
  - `frame_done` pulses one cycle later.
- Backpressure: `out_ready` low for 5 cycles at beat 2 -> X=2 and a held for all 5 cycles; frame still 12 beats; `stall_count`=5 when enabled.
- Wrap: re_origin=0x7FFFFFFF, delta_x=1 -> beat 1 a=0x80000000.
- `start` pulsed during SCAN with new origins -> ignored; frame completes with the original values.
- `rst` asserted at beat 6 -> next cycle IDLE with all outputs at reset values and no `frame_done`; a following `start` begins at X=0, Y=0.
- `start` high continuously -> frames run back to back with exactly one DONE and one IDLE cycle between the last beat and the next first beat.
